fc_layer_ctrl: RTL and testbench

- Sequencer that drives the shared control bus of a fully-connected layer's neuron array.
- Accepts one input vector as a serial valid/ready word stream. Issues weight-ROM addresses, plus data and sum_en timed one cycle behind the address, to cover the ROM's one-cycle read latency.
- Then issues the bias address and an add_bias pulse. Holds a layer-valid handshake until downstream takes the neuron outputs.
- Sits between the previous layer's output stream and all fc_neuron instances of one layer.

---
 rtl/fc_ctrl_pkg.sv | 21 ++
 rtl/fc_index_counter.sv | 33 +++
 rtl/fc_layer_ctrl.sv | 136 +++++++++++++
 tb/tb_fc_layer_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fc_ctrl_pkg
// Shared definitions for the fully-connected layer controller.
//   fc_state_t : controller phase (ACCUM, BIAS, WAIT, OUT)
//   bias_addr  : ROM address holding the bias; it sits just past the
//                last weight row, so it equals the layer height.
// -----------------------------------------------------------------------------
package fc_ctrl_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    BIAS  = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } fc_state_t;

  function automatic int bias_addr(input int height);
    return height;
  endfunction

endpackage

// File: rtl/fc_index_counter.sv
// -----------------------------------------------------------------------------
// fc_index_counter
// Modulo-N up counter with enable, terminal-count flag and async clear.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low clear (count -> 0)
//   en    : advance by one this cycle (wraps N-1 -> 0)
//   count : current value, 0..N-1
//   tc    : high while count == N-1 (always high when N == 1)
// -----------------------------------------------------------------------------
module fc_index_counter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/fc_layer_ctrl.sv
// -----------------------------------------------------------------------------
// fc_layer_ctrl
// Sequencer for the shared control bus of one fully-connected layer.
// Takes one input vector of PREVIOUS_LAYER_HEIGHT words, streams weight
// addresses to the neurons, then the bias address and an add_bias pulse,
// then offers the neuron results downstream until they are taken.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising edge. The sender holds valid (and its data) until that
// cycle; ready never depends on valid. Input side is valid_i/ready_o,
// output side is valid_o/ready_i.
//
// Ports
//   clk_i       : clock, rising edge
//   reset_i     : asynchronous active-low reset
//   valid_i     : input word valid
//   data_i      : input word (signed)
//   ready_o     : controller accepts an input word (function of state only)
//   w_addr_o    : weight/bias ROM address broadcast to all neurons
//   data_o      : registered input word broadcast to all neurons
//   sum_en_o    : neuron multiply-accumulate enable
//   add_bias_o  : neuron bias-add / finalise pulse
//   valid_o     : neuron outputs hold a complete result
//   ready_i     : downstream takes the result
//   dbg_state_o : current controller state
//   dbg_wait_o  : current wait-counter value (zero-extended)
// -----------------------------------------------------------------------------
module fc_layer_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int WORD_SIZE             = 16,
  parameter int PREVIOUS_LAYER_HEIGHT = 4,
  parameter int RAM_ADDRESS_BITS      = $clog2(PREVIOUS_LAYER_HEIGHT + 1),
  parameter int ALU_LATENCY           = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        valid_i,
  input  logic [WORD_SIZE-1:0]        data_i,
  output logic                        ready_o,
  output logic [RAM_ADDRESS_BITS-1:0] w_addr_o,
  output logic [WORD_SIZE-1:0]        data_o,
  output logic                        sum_en_o,
  output logic                        add_bias_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output fc_state_t                   dbg_state_o,
  output logic [7:0]                  dbg_wait_o
);

  localparam int CNT_BITS  = (PREVIOUS_LAYER_HEIGHT > 1) ? $clog2(PREVIOUS_LAYER_HEIGHT) : 1;
  localparam int WAIT_BITS = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [RAM_ADDRESS_BITS-1:0] BIAS_ADDR =
    RAM_ADDRESS_BITS'(bias_addr(PREVIOUS_LAYER_HEIGHT));

  fc_state_t            state_q;
  fc_state_t            state_d;
  logic [CNT_BITS-1:0]  cnt;
  logic                 cnt_tc;
  logic [WAIT_BITS-1:0] wait_cnt;
  logic                 wait_tc;
  logic                 accept;

  assign accept      = valid_i && ready_o;
  assign dbg_state_o = state_q;
  assign dbg_wait_o  = 8'(wait_cnt);

  // Word index within the vector; wraps to 0 on the last word so the next
  // vector starts at address 0 without an explicit clear.
  fc_index_counter #(
    .N (PREVIOUS_LAYER_HEIGHT),
    .W (CNT_BITS)
  ) u_word_cnt (
    .clk   (clk_i),
    .rst_n (reset_i),
    .en    (accept),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // Cycles spent in WAIT; wraps to 0 as WAIT is left.
  fc_index_counter #(
    .N (ALU_LATENCY),
    .W (WAIT_BITS)
  ) u_wait_cnt (
    .clk   (clk_i),
    .rst_n (reset_i),
    .en    (state_q == WAIT),
    .count (wait_cnt),
    .tc    (wait_tc)
  );

  always_comb begin
    state_d  = state_q;
    ready_o  = 1'b0;
    w_addr_o = '0;
    unique case (state_q)
      ACCUM: begin
        ready_o  = 1'b1;
        w_addr_o = RAM_ADDRESS_BITS'(cnt);
        if (valid_i && cnt_tc) state_d = BIAS;
      end
      BIAS: begin
        w_addr_o = BIAS_ADDR;
        state_d  = WAIT;
      end
      WAIT: begin
        if (wait_tc) state_d = OUT;
      end
      OUT: begin
        if (ready_i) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Neuron controls trail the address by one cycle to match the ROM's
  // read latency: the word accepted while w_addr_o = k is on data_o with
  // sum_en_o high exactly when the ROM delivers weight k.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= ACCUM;
      data_o     <= '0;
      sum_en_o   <= 1'b0;
      add_bias_o <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_en_o   <= accept;
      add_bias_o <= (state_q == BIAS);
      valid_o    <= (state_d == OUT);
      if (accept) data_o <= data_i;
    end
  end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fc_layer_ctrl
// Two instances: A (H=4, ALU_LATENCY=1) and B (H=1, ALU_LATENCY=3).
// Inputs change 1 time unit after the rising edge; outputs are compared
// on the falling edge against a timestamp-based model of the layer.
// -----------------------------------------------------------------------------
module tb_fc_layer_ctrl;
  import fc_ctrl_pkg::*;

  localparam int HA = 4;
  localparam int LA = 1;
  localparam int HB = 1;
  localparam int LB = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- DUT A ----------------
  logic        va, ra;
  logic [15:0] da;
  logic        ready_a, sum_en_a, ab_a, valid_a;
  logic [2:0]  addr_a;
  logic [15:0] data_a;
  fc_state_t   st_a;
  logic [7:0]  wt_a;

  fc_layer_ctrl #(
    .WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(HA), .ALU_LATENCY(LA)
  ) dut_a (
    .clk_i(clk), .reset_i(rst_n), .valid_i(va), .data_i(da),
    .ready_o(ready_a), .w_addr_o(addr_a), .data_o(data_a),
    .sum_en_o(sum_en_a), .add_bias_o(ab_a), .valid_o(valid_a),
    .ready_i(ra), .dbg_state_o(st_a), .dbg_wait_o(wt_a)
  );

  // ---------------- DUT B ----------------
  logic        vb, rb;
  logic [15:0] db;
  logic        ready_b, sum_en_b, ab_b, valid_b;
  logic [0:0]  addr_b;
  logic [15:0] data_b;
  fc_state_t   st_b;
  logic [7:0]  wt_b;

  fc_layer_ctrl #(
    .WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(HB), .ALU_LATENCY(LB)
  ) dut_b (
    .clk_i(clk), .reset_i(rst_n), .valid_i(vb), .data_i(db),
    .ready_o(ready_b), .w_addr_o(addr_b), .data_o(data_b),
    .sum_en_o(sum_en_b), .add_bias_o(ab_b), .valid_o(valid_b),
    .ready_i(rb), .dbg_state_o(st_b), .dbg_wait_o(wt_b)
  );

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model per instance: number of words taken in the current vector,
  // cycle of the final word, and last accepted word.
  int          taken   [2];
  int          t_last  [2];
  int          d_exp   [2];
  bit          prev_hs [2];
  logic [15:0] exp_q[$];      // word order seen by instance A's neurons
  bit          rec_ab = 1'b0;
  int          ab_q[$];

  task automatic model_step(input int i, input int h, input int l, input bit rst,
                            input bit vi, input int di, input bit ri,
                            input int ready, input int addr, input int data,
                            input int sum_en, input int add_bias, input int valid);
    int  e_ready, e_addr, e_ab, e_valid;
    bit  hs;
    string p;
    p = (i == 0) ? "A_" : "B_";
    if (!rst) begin
      chk({p, "rst_ready"}, ready, 1);
      chk({p, "rst_addr"}, addr, 0);
      chk({p, "rst_data"}, data, 0);
      chk({p, "rst_sum_en"}, sum_en, 0);
      chk({p, "rst_add_bias"}, add_bias, 0);
      chk({p, "rst_valid"}, valid, 0);
      taken[i]   = 0;
      t_last[i]  = -100;
      d_exp[i]   = 0;
      prev_hs[i] = 1'b0;
      if (i == 0) exp_q.delete();
      return;
    end
    e_ready = (taken[i] < h) ? 1 : 0;
    if (e_ready == 1)             e_addr = taken[i];
    else if (cyc == t_last[i] + 1) e_addr = h;
    else                           e_addr = 0;
    e_ab    = (taken[i] == h && cyc == t_last[i] + 2) ? 1 : 0;
    e_valid = (taken[i] == h && cyc >= t_last[i] + 2 + l) ? 1 : 0;

    chk({p, "ready"}, ready, e_ready);
    chk({p, "w_addr"}, addr, e_addr);
    chk({p, "sum_en"}, sum_en, prev_hs[i] ? 1 : 0);
    chk({p, "data"}, data, d_exp[i]);
    chk({p, "add_bias"}, add_bias, e_ab);
    chk({p, "valid"}, valid, e_valid);

    if (i == 0 && sum_en == 1) begin
      chk("A_sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) chk("A_sb_word", data, int'(exp_q.pop_front()));
    end
    if (i == 0 && rec_ab && add_bias == 1) ab_q.push_back(cyc);

    hs = vi && (e_ready == 1);
    prev_hs[i] = hs;
    if (hs) begin
      d_exp[i] = di;
      if (i == 0) exp_q.push_back(di[15:0]);
      taken[i]++;
      if (taken[i] == h) t_last[i] = cyc;
    end
    if (e_valid == 1 && ri) taken[i] = 0;
  endtask

  always @(negedge clk) begin
    model_step(0, HA, LA, rst_n, va, int'(da), ra,
               int'(ready_a), int'(addr_a), int'(data_a),
               int'(sum_en_a), int'(ab_a), int'(valid_a));
    model_step(1, HB, LB, rst_n, vb, int'(db), rb,
               int'(ready_b), int'(addr_b), int'(data_b),
               int'(sum_en_b), int'(ab_b), int'(valid_b));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at edge+1; holds valid with the word until it is accepted.
  task automatic send(input int i, input logic [15:0] w, input int gap);
    bit done = 1'b0;
    if (i == 0) va = 1'b0; else vb = 1'b0;
    repeat (gap) step();
    if (i == 0) begin va = 1'b1; da = w; end
    else        begin vb = 1'b1; db = w; end
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = (i == 0) ? ready_a : ready_b;
      step();
    end
    if (i == 0) va = 1'b0; else vb = 1'b0;
    chk("send_accepted", done ? 1 : 0, 1);
  endtask

  bit rand_rdy = 1'b0;
  initial forever begin
    step();
    if (rand_rdy) ra = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    va = 1'b0; da = '0; ra = 1'b0;
    vb = 1'b0; db = '0; rb = 1'b0;
    repeat (3) step();
    chk("A_lit_rst_ready", int'(ready_a), 1);
    chk("A_lit_rst_valid", int'(valid_a), 0);
    rst_n = 1'b1;

    // Directed vector 10,20,30,40 on consecutive cycles, downstream stalls.
    send(0, 16'd10, 0);
    send(0, 16'd20, 0);
    send(0, 16'd30, 0);
    send(0, 16'd40, 0);
    @(negedge clk);
    chk("A_lit_bias_addr", int'(addr_a), 4);
    chk("A_lit_last_sum_en", int'(sum_en_a), 1);
    chk("A_lit_last_data", int'(data_a), 40);
    @(negedge clk);
    chk("A_lit_add_bias", int'(ab_a), 1);
    chk("A_lit_ab_no_sum", int'(sum_en_a), 0);
    chk("A_lit_not_valid_yet", int'(valid_a), 0);
    @(negedge clk);
    chk("A_lit_valid", int'(valid_a), 1);
    repeat (5) begin
      @(negedge clk);
      chk("A_lit_hold_valid", int'(valid_a), 1);
      chk("A_lit_hold_ready", int'(ready_a), 0);
      chk("A_lit_hold_addr", int'(addr_a), 0);
    end
    step();
    ra = 1'b1;
    step();
    ra = 1'b0;
    @(negedge clk);
    chk("A_lit_taken_valid", int'(valid_a), 0);
    chk("A_lit_taken_ready", int'(ready_a), 1);
    step();

    // Same vector with a two-cycle gap before the third word.
    send(0, 16'd10, 0);
    send(0, 16'd20, 0);
    send(0, 16'd30, 2);
    send(0, 16'd40, 0);
    ra = 1'b1;
    repeat (6) step();
    ra = 1'b0;

    // Asynchronous reset after two accepted words.
    send(0, 16'd111, 0);
    send(0, 16'd222, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("A_lit_async_addr", int'(addr_a), 0);
    chk("A_lit_async_data", int'(data_a), 0);
    chk("A_lit_async_sum_en", int'(sum_en_a), 0);
    chk("A_lit_async_ready", int'(ready_a), 1);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("A_lit_restart_addr", int'(addr_a), 0);
    step();
    send(0, 16'd1, 0);
    send(0, 16'd2, 0);
    send(0, 16'd3, 0);
    send(0, 16'd4, 0);
    ra = 1'b1;
    repeat (6) step();

    // Random words, random gaps, random downstream readiness.
    rand_rdy = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int w = 0; w < HA; w++) send(0, 16'($urandom), $urandom_range(0, 2));
    end
    repeat (12) step();
    rand_rdy = 1'b0;
    step();
    ra = 1'b1;
    repeat (8) step();

    // Back-to-back vectors, valid and ready tied high. One vector spans
    // four accept cycles, one bias cycle, LA wait cycles and one out cycle.
    rec_ab = 1'b1;
    va = 1'b1;
    repeat (40) begin
      da = 16'($urandom);
      step();
    end
    va = 1'b0;
    repeat (8) step();
    rec_ab = 1'b0;
    chk("A_b2b_vectors", (ab_q.size() >= 4) ? 1 : 0, 1);
    for (int k = 1; k < ab_q.size(); k++)
      chk("A_b2b_period", ab_q[k] - ab_q[k-1], HA + 1 + LA + 1);
    ra = 1'b0;

    // Instance B: single-word vector, ALU latency 3, word -7.
    send(1, 16'hFFF9, 0);
    @(negedge clk);
    chk("B_lit_sum_en", int'(sum_en_b), 1);
    chk("B_lit_data", int'(data_b), 16'hFFF9);
    chk("B_lit_bias_addr", int'(addr_b), 1);
    @(negedge clk);
    chk("B_lit_add_bias", int'(ab_b), 1);
    repeat (2) begin
      @(negedge clk);
      chk("B_lit_waiting", int'(valid_b), 0);
    end
    @(negedge clk);
    chk("B_lit_valid", int'(valid_b), 1);
    step();
    rb = 1'b1;
    step();
    rb = 1'b0;
    repeat (3) step();

    chk("A_sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
